// File: rtl/gpio_irq_pkg.sv
// GPIO controller shared constants: register offsets,
// pin-mode encodings and the byte-lane mask helper.
package gpio_irq_pkg;

   localparam logic [7:0] GPIO_DIN   = 8'h00;
   localparam logic [7:0] GPIO_OPT   = 8'h04;
   localparam logic [7:0] GPIO_OEC   = 8'h08;
   localparam logic [7:0] GPIO_ODC   = 8'h0C;
   localparam logic [7:0] GPIO_IEN   = 8'h10;
   localparam logic [7:0] GPIO_ITYP  = 8'h14;
   localparam logic [7:0] GPIO_IPOL  = 8'h18;
   localparam logic [7:0] GPIO_IBOTH = 8'h1C;
   localparam logic [7:0] GPIO_IPEND = 8'h20;
   localparam logic [7:0] GPIO_DEBC  = 8'h24;
   localparam logic [7:0] GPIO_OSET  = 8'h28;
   localparam logic [7:0] GPIO_OCLR  = 8'h2C;

   // {OEC, ODC} per pin
   localparam logic [1:0] GPIO_MODE_IN    = 2'b00;
   localparam logic [1:0] GPIO_MODE_LATCH = 2'b01;
   localparam logic [1:0] GPIO_MODE_PP    = 2'b10;
   localparam logic [1:0] GPIO_MODE_OD    = 2'b11;

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/gpio_in_filt.sv
// Input conditioning: multi-flop synchroniser, shared debounce
// tick counter and per-pin two-sample agreement filter.
module gpio_in_filt
   import gpio_irq_pkg::*;
#(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GPIO_W-1:0] i_pin,
   input  logic [DEB_W-1:0]  i_period,
   input  logic              i_clr,
   output logic [GPIO_W-1:0] o_filt
);

   logic [GPIO_W-1:0] r_sync [SYNC_STAGES];
   logic [DEB_W-1:0]  r_cnt;
   logic [GPIO_W-1:0] r_prev;
   logic [GPIO_W-1:0] r_filt;
   logic [GPIO_W-1:0] w_sync;
   logic [GPIO_W-1:0] w_eq;
   logic              w_deb_on;
   logic              w_tick;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_deb_on = (i_period != '0);
   assign w_tick   = w_deb_on & (r_cnt == i_period - DEB_W'(1));
   assign w_eq     = ~(w_sync ^ r_prev);
   assign o_filt   = r_filt;

   // shift the asynchronous pad values through the synchroniser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= i_pin;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // tick counter runs 0..N-1, idles at 0 when the filter is off
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_clr || w_tick || !w_deb_on)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + DEB_W'(1);
   end

   // remember the sample taken at the previous tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_prev <= '0;
      else if (i_clr)
         r_prev <= '0;
      else if (w_tick)
         r_prev <= w_sync;
   end

   // accept a new value only when two consecutive ticks agree
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_filt <= '0;
      else if (!w_deb_on)
         r_filt <= w_sync;
      else if (w_tick && !i_clr)
         r_filt <= (w_sync & w_eq) | (r_filt & ~w_eq);
   end

endmodule

// File: rtl/gpio_irq.sv
// GPIO controller top: register file, pin-mode decode,
// per-pin interrupt detection and registered read mux.
module gpio_irq
   import gpio_irq_pkg::*;
#(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        waddr_i,
   input  logic [31:0]       data_i,
   input  logic [3:0]        sel_i,
   input  logic              we_i,
   input  logic [7:0]        raddr_i,
   input  logic              rd_i,
   output logic [31:0]       data_o,
   output logic [GPIO_W-1:0] gpio_oe,
   output logic [GPIO_W-1:0] gpio_out,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic              irq_o
);

   logic [GPIO_W-1:0] r_opt, r_oec, r_odc;
   logic [GPIO_W-1:0] r_ien, r_ityp, r_ipol, r_iboth;
   logic [GPIO_W-1:0] r_ipend, r_hold, r_fp;
   logic [DEB_W-1:0]  r_debc;
   logic [31:0]       r_data;

   logic [31:0]       w_bm, w_wd, w_rdata;
   logic [GPIO_W-1:0] w_bm_p, w_wd_p;
   logic [GPIO_W-1:0] w_filt, w_din, w_latch;
   logic [GPIO_W-1:0] w_oe, w_out;
   logic [GPIO_W-1:0] w_chg, w_match, w_edge, w_ev, w_clr;
   logic w_wr_opt, w_wr_oec, w_wr_odc, w_wr_ien;
   logic w_wr_ityp, w_wr_ipol, w_wr_iboth, w_wr_ipend;
   logic w_wr_debc, w_wr_oset, w_wr_oclr;

   assign w_bm   = lane_mask(sel_i);
   assign w_wd   = data_i & w_bm;
   assign w_bm_p = w_bm[GPIO_W-1:0];
   assign w_wd_p = w_wd[GPIO_W-1:0];

   assign w_wr_opt   = we_i && (waddr_i == GPIO_OPT);
   assign w_wr_oec   = we_i && (waddr_i == GPIO_OEC);
   assign w_wr_odc   = we_i && (waddr_i == GPIO_ODC);
   assign w_wr_ien   = we_i && (waddr_i == GPIO_IEN);
   assign w_wr_ityp  = we_i && (waddr_i == GPIO_ITYP);
   assign w_wr_ipol  = we_i && (waddr_i == GPIO_IPOL);
   assign w_wr_iboth = we_i && (waddr_i == GPIO_IBOTH);
   assign w_wr_ipend = we_i && (waddr_i == GPIO_IPEND);
   assign w_wr_debc  = we_i && (waddr_i == GPIO_DEBC);
   assign w_wr_oset  = we_i && (waddr_i == GPIO_OSET);
   assign w_wr_oclr  = we_i && (waddr_i == GPIO_OCLR);

   gpio_in_filt #(
      .GPIO_W      (GPIO_W),
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W)
   ) u_filt (
      .clk      (clk),
      .rst      (rst),
      .i_pin    (gpio_in),
      .i_period (r_debc),
      .i_clr    (w_wr_debc),
      .o_filt   (w_filt)
   );

   // output register: lane write, atomic set, atomic clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_opt <= '0;
      else if (w_wr_opt)
         r_opt <= (r_opt & ~w_bm_p) | w_wd_p;
      else if (w_wr_oset)
         r_opt <= r_opt | w_wd_p;
      else if (w_wr_oclr)
         r_opt <= r_opt & ~w_wd_p;
   end

   // plain read-write configuration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_oec   <= '0;
         r_odc   <= '0;
         r_ien   <= '0;
         r_ityp  <= '0;
         r_ipol  <= '0;
         r_iboth <= '0;
         r_debc  <= '0;
      end else begin
         if (w_wr_oec)   r_oec   <= (r_oec   & ~w_bm_p) | w_wd_p;
         if (w_wr_odc)   r_odc   <= (r_odc   & ~w_bm_p) | w_wd_p;
         if (w_wr_ien)   r_ien   <= (r_ien   & ~w_bm_p) | w_wd_p;
         if (w_wr_ityp)  r_ityp  <= (r_ityp  & ~w_bm_p) | w_wd_p;
         if (w_wr_ipol)  r_ipol  <= (r_ipol  & ~w_bm_p) | w_wd_p;
         if (w_wr_iboth) r_iboth <= (r_iboth & ~w_bm_p) | w_wd_p;
         if (w_wr_debc)
            r_debc <= (r_debc & ~w_bm[DEB_W-1:0]) | w_wd[DEB_W-1:0];
      end
   end

   // decode {OEC, ODC} into pad drive and input-latch select
   always_comb begin
      w_oe    = '0;
      w_out   = '0;
      w_latch = '0;
      for (int i = 0; i < GPIO_W; i++) begin
         case ({r_oec[i], r_odc[i]})
            GPIO_MODE_LATCH: w_latch[i] = 1'b1;
            GPIO_MODE_PP: begin
               w_oe[i]  = 1'b1;
               w_out[i] = r_opt[i];
            end
            GPIO_MODE_OD: w_oe[i] = ~r_opt[i];
            default: ;
         endcase
      end
   end

   assign gpio_oe  = w_oe;
   assign gpio_out = w_out;

   // latched pins read the value held at mode entry
   assign w_din = (w_latch & r_hold) | (~w_latch & w_filt);

   // r_hold tracks DIN so it freezes on entering latch mode;
   // r_fp is DIN delayed one cycle for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold <= '0;
         r_fp   <= '0;
      end else begin
         r_hold <= w_din;
         r_fp   <= w_din;
      end
   end

   assign w_chg   = w_din ^ r_fp;
   assign w_match = ~(w_din ^ r_ipol);
   assign w_edge  = (r_iboth & w_chg) | (~r_iboth & w_chg & w_match);
   assign w_ev    = (r_ityp & w_edge) | (~r_ityp & w_match);
   assign w_clr   = w_wr_ipend ? w_wd_p : '0;

   // pending bits: enabled events set, W1C clears, set wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ipend <= '0;
      else
         r_ipend <= (r_ipend & ~w_clr) | (w_ev & r_ien);
   end

   assign irq_o = |(r_ipend & r_ien);

   // read mux; write-only and unmapped offsets return zero
   always_comb begin
      w_rdata = '0;
      case (raddr_i)
         GPIO_DIN:   w_rdata = 32'(w_din);
         GPIO_OPT:   w_rdata = 32'(r_opt);
         GPIO_OEC:   w_rdata = 32'(r_oec);
         GPIO_ODC:   w_rdata = 32'(r_odc);
         GPIO_IEN:   w_rdata = 32'(r_ien);
         GPIO_ITYP:  w_rdata = 32'(r_ityp);
         GPIO_IPOL:  w_rdata = 32'(r_ipol);
         GPIO_IBOTH: w_rdata = 32'(r_iboth);
         GPIO_IPEND: w_rdata = 32'(r_ipend);
         GPIO_DEBC:  w_rdata = 32'(r_debc);
         default:    w_rdata = '0;
      endcase
   end

   // registered read data, held while no read is issued
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_data <= '0;
      else if (rd_i)
         r_data <= w_rdata;
   end

   assign data_o = r_data;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: a 32-pin and an 8-pin instance
// share the bus; expected values are hand-computed constants.
module tb_gpio_irq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  waddr_i = '0;
   logic [31:0] data_i = '0;
   logic [3:0]  sel_i = '0;
   logic        we_i = 1'b0;
   logic [7:0]  raddr_i = '0;
   logic        rd_i = 1'b0;
   logic [31:0] gpio_in = '0;

   logic [31:0] data_o, gpio_oe, gpio_out;
   logic        irq_o;
   logic [31:0] data_o8;
   logic [7:0]  gpio_oe8, gpio_out8;
   logic        irq_o8;

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gpio_irq u_dut (
      .clk      (clk),
      .rst      (rst),
      .waddr_i  (waddr_i),
      .data_i   (data_i),
      .sel_i    (sel_i),
      .we_i     (we_i),
      .raddr_i  (raddr_i),
      .rd_i     (rd_i),
      .data_o   (data_o),
      .gpio_oe  (gpio_oe),
      .gpio_out (gpio_out),
      .gpio_in  (gpio_in),
      .irq_o    (irq_o)
   );

   gpio_irq #(.GPIO_W(8)) u_dut8 (
      .clk      (clk),
      .rst      (rst),
      .waddr_i  (waddr_i),
      .data_i   (data_i),
      .sel_i    (sel_i),
      .we_i     (we_i),
      .raddr_i  (raddr_i),
      .rd_i     (rd_i),
      .data_o   (data_o8),
      .gpio_oe  (gpio_oe8),
      .gpio_out (gpio_out8),
      .gpio_in  (gpio_in[7:0]),
      .irq_o    (irq_o8)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      waddr_i = a;
      data_i  = d;
      sel_i   = s;
      we_i    = 1'b1;
      step(1);
      we_i    = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      raddr_i = a;
      rd_i    = 1'b1;
      step(1);
      rd_i    = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      step(2);
      chk("rst_data", data_o, 32'h0);
      chk("rst_oe", gpio_oe, 32'h0);
      chk("rst_out", gpio_out, 32'h0);
      chk("rst_irq", {31'h0, irq_o}, 32'h0);
      rst = 1'b0;
      step(1);
      rd(8'h00);
      chk("rst_din", data_o, 32'h0);

      // byte lanes and atomic set/clear
      wr(8'h04, 32'hFFFF_FFFF, 4'b0101);
      rd(8'h04);
      chk("opt_lanes", data_o, 32'h00FF_00FF);
      wr(8'h28, 32'h0000_0100, 4'hF);
      rd(8'h04);
      chk("opt_set", data_o, 32'h00FF_01FF);
      wr(8'h2C, 32'h0000_00FF, 4'hF);
      rd(8'h04);
      chk("opt_clr", data_o, 32'h00FF_0100);
      rd(8'h28);
      chk("oset_rd0", data_o, 32'h0);

      // pin modes on pin0
      wr(8'h2C, 32'hFFFF_FFFF, 4'hF);
      wr(8'h28, 32'h1, 4'hF);
      wr(8'h08, 32'h1, 4'hF);
      chk("pp_oe", gpio_oe, 32'h1);
      chk("pp_out", gpio_out, 32'h1);
      wr(8'h0C, 32'h1, 4'hF);
      chk("od_oe1", gpio_oe, 32'h0);
      chk("od_out1", gpio_out, 32'h0);
      wr(8'h2C, 32'h1, 4'hF);
      chk("od_oe0", gpio_oe, 32'h1);
      chk("od_out0", gpio_out, 32'h0);
      wr(8'h08, 32'h0, 4'hF);
      gpio_in = 32'h11;
      step(6);
      rd(8'h00);
      chk("latch_din", data_o, 32'h10);
      gpio_in = 32'h0;
      step(4);
      wr(8'h0C, 32'h0, 4'hF);
      rd(8'h00);
      chk("latch_exit", data_o, 32'h0);

      // debounce on pin1
      wr(8'h24, 32'h4, 4'hF);
      rd(8'h24);
      chk("debc_rd", data_o, 32'h4);
      gpio_in = 32'h2;
      step(3);
      gpio_in = 32'h0;
      step(10);
      rd(8'h00);
      chk("deb_glitch", data_o, 32'h0);
      gpio_in = 32'h2;
      step(11);
      rd(8'h00);
      chk("deb_stable", data_o, 32'h2);
      wr(8'h24, 32'h0, 4'hF);
      gpio_in = 32'h0;
      step(4);
      rd(8'h00);
      chk("deb_off", data_o, 32'h0);
      rd(8'h20);
      chk("no_ien", data_o, 32'h0);

      // edge interrupt on pin2
      wr(8'h14, 32'h4, 4'hF);
      wr(8'h18, 32'h4, 4'hF);
      wr(8'h10, 32'h4, 4'hF);
      chk("edge_idle", {31'h0, irq_o}, 32'h0);
      gpio_in = 32'h4;
      step(3);
      chk("edge_c3", {31'h0, irq_o}, 32'h0);
      step(1);
      chk("edge_c4", {31'h0, irq_o}, 32'h1);
      rd(8'h20);
      chk("edge_pend", data_o, 32'h4);
      wr(8'h20, 32'h4, 4'hF);
      rd(8'h20);
      chk("edge_w1c", data_o, 32'h0);
      gpio_in = 32'h0;
      step(6);
      rd(8'h20);
      chk("fall_none", data_o, 32'h0);
      wr(8'h1C, 32'h4, 4'hF);
      gpio_in = 32'h4;
      step(6);
      wr(8'h20, 32'h4, 4'hF);
      gpio_in = 32'h0;
      step(6);
      rd(8'h20);
      chk("both_fall", data_o, 32'h4);
      chk("both_irq", {31'h0, irq_o}, 32'h1);
      wr(8'h20, 32'h4, 4'hF);
      rd(8'h20);
      chk("both_w1c", data_o, 32'h0);

      // level interrupt on pin3, low active, clear race
      wr(8'h10, 32'h8, 4'hF);
      step(1);
      chk("lvl_irq", {31'h0, irq_o}, 32'h1);
      wr(8'h20, 32'h8, 4'hF);
      rd(8'h20);
      chk("lvl_setwins", data_o, 32'h8);
      wr(8'h20, 32'h8, 4'b1110);
      wr(8'h10, 32'h0, 4'hF);
      chk("ien_off_irq", {31'h0, irq_o}, 32'h0);
      rd(8'h20);
      chk("ien_off_pend", data_o, 32'h8);
      wr(8'h10, 32'h8, 4'hF);
      gpio_in = 32'h8;
      step(5);
      wr(8'h20, 32'h8, 4'hF);
      chk("lvl_clr_irq", {31'h0, irq_o}, 32'h0);
      rd(8'h20);
      chk("lvl_clr", data_o, 32'h0);

      // narrow instance
      wr(8'h08, 32'hFFFF_FFFF, 4'hF);
      rd(8'h08);
      chk("w8_oec", data_o8, 32'h0000_00FF);
      chk("w8_oe", {24'h0, gpio_oe8}, 32'h0000_00FF);
      rd(8'h30);
      chk("w8_unmap", data_o8, 32'h0);
      chk("unmap", data_o, 32'h0);

      // reset in the middle of a debounce period
      wr(8'h28, 32'hF, 4'hF);
      wr(8'h18, 32'h8, 4'hF);
      wr(8'h24, 32'h4, 4'hF);
      step(2);
      rd(8'h08);
      chk("pre_out", gpio_out, 32'hF);
      chk("pre_irq", {31'h0, irq_o}, 32'h1);
      chk("pre_data", data_o, 32'hFFFF_FFFF);
      rst = 1'b1;
      #1;
      chk("mid_oe", gpio_oe, 32'h0);
      chk("mid_out", gpio_out, 32'h0);
      chk("mid_irq", {31'h0, irq_o}, 32'h0);
      chk("mid_data", data_o, 32'h0);
      chk("mid_oe8", {24'h0, gpio_oe8}, 32'h0);
      gpio_in = 32'h0;
      step(2);
      rst = 1'b0;
      step(1);
      rd(8'h24);
      chk("post_debc", data_o, 32'h0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
